chess_packet_tx: RTL



---
 rtl/chess_packet_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/chess_packet_tx.sv
// chess_packet_tx: encodes setup/move events into 16-bit packets, queues them and paces them to the UART TX.
// Ports:
//   clk, reset_n (async, active-low)
//   setup_req_i, setup_player_i, setup_mode_i[1:0]  setup packet request and operands
//   move_req_i, src_x_i, src_y_i, dst_x_i, dst_y_i   move packet request and local (unmirrored) coordinates
//   flush_i        synchronous queue clear
//   clr_overflow_i clears the overflow sticky
//   tx_data_o[15:0], tx_valid_o  packet and one-cycle strobe to the UART
//   pkt_sent_o     one-cycle pulse coincident with tx_valid_o
//   level_o, queue_empty_o, queue_full_o, overflow_o  queue status
// Optional: define CHESS_TX_CHECKSUM_EN to place a 2-bit XOR checksum in move packet bits [1:0].
module chess_packet_tx #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 8700
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       setup_req_i,
    input  logic                       setup_player_i,
    input  logic [1:0]                 setup_mode_i,
    input  logic                       move_req_i,
    input  logic [2:0]                 src_x_i,
    input  logic [2:0]                 src_y_i,
    input  logic [2:0]                 dst_x_i,
    input  logic [2:0]                 dst_y_i,
    input  logic                       flush_i,
    input  logic                       clr_overflow_i,
    output logic [15:0]                tx_data_o,
    output logic                       tx_valid_o,
    output logic                       pkt_sent_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       queue_empty_o,
    output logic                       queue_full_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(GAP_CYCLES);

    typedef enum logic {IDLE, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic [15:0]     tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     mem_q [DEPTH];

    logic [11:0]     coords;
    logic [1:0]      move_cs;
    logic [15:0]     enq_pkt;
    logic            req, pop, accept, drop;

    assign coords = {src_x_i, src_y_i, dst_x_i, dst_y_i};
`ifdef CHESS_TX_CHECKSUM_EN
    assign move_cs = coords[11:10] ^ coords[9:8] ^ coords[7:6] ^ coords[5:4] ^ coords[3:2] ^ coords[1:0];
`else
    assign move_cs = 2'b00;
`endif
    // Setup wins a same-cycle collision; the move is the one dropped.
    assign enq_pkt = setup_req_i ? {2'b10, setup_player_i, setup_mode_i, 11'b0} : {2'b00, coords, move_cs};

    // A flush discards the head too, so it suppresses the pop.
    assign pop    = (state_q == IDLE) && (level_q != '0) && !flush_i;
    assign req    = setup_req_i | move_req_i;
    // A full queue still accepts when the head leaves on the same edge.
    assign accept = req && !flush_i && ((level_q != LW'(DEPTH)) || pop);
    assign drop   = (setup_req_i && move_req_i) || (req && !flush_i && !accept);

    always_comb begin
        level_d    = flush_i ? '0 : level_q + LW'(accept) - LW'(pop);
        wr_ptr_d   = flush_i ? '0 : wr_ptr_q + AW'(accept);
        rd_ptr_d   = flush_i ? '0 : rd_ptr_q + AW'(pop);
        overflow_d = drop ? 1'b1 : (clr_overflow_i ? 1'b0 : overflow_q);
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (pop) begin
                state_d    = GAP;
                gap_d      = CW'(GAP_CYCLES - 2);
                tx_data_d  = mem_q[rd_ptr_q];
                tx_valid_d = 1'b1;
            end
        end else begin
            gap_d   = (gap_q == '0) ? '0 : gap_q - CW'(1);
            state_d = (gap_q == '0) ? IDLE : GAP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= enq_pkt;
    end

    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign pkt_sent_o    = tx_valid_q;
    assign level_o       = level_q;
    assign queue_empty_o = (level_q == '0);
    assign queue_full_o  = (level_q == LW'(DEPTH));
    assign overflow_o    = overflow_q;
endmodule
